// File: rtl/display_scan_mux_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and channel-search helpers for the
//               seven-segment display scanner.
// Contents    : DISP_* default constants, next_enabled(), lowest_enabled()
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int DISP_N_CH      = 8;
  localparam int DISP_DATA_W    = 4;
  localparam int DISP_DIGIT_CYC = 100000;
  localparam int DISP_BLANK_CYC = 1000;

  // Largest channel count the search helpers handle.
  localparam int DISP_MAX_CH    = 32;

  // Rotating search: first enabled channel after sel, wrapping modulo n_ch.
  // Returns sel itself when it is the only enabled channel (the search
  // reaches it again at step n_ch) or when no channel is enabled.
  function automatic int unsigned next_enabled(
    input int unsigned            sel,
    input logic [DISP_MAX_CH-1:0] mask,
    input int unsigned            n_ch
  );
    int unsigned idx;
    int unsigned res;
    logic        found;
    res   = sel;
    found = 1'b0;
    for (int i = 1; i <= DISP_MAX_CH; i++) begin
      idx = sel + int'(i);
      if (idx >= n_ch) idx = idx - n_ch;
      if (!found && (int'(i) <= int'(n_ch)) && mask[idx[4:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Index of the lowest enabled channel (0 when none is enabled).
  function automatic int unsigned lowest_enabled(
    input logic [DISP_MAX_CH-1:0] mask,
    input int unsigned            n_ch
  );
    int unsigned res;
    res = 0;
    for (int i = DISP_MAX_CH - 1; i >= 0; i--) begin
      if ((i < int'(n_ch)) && mask[i]) res = i;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/display_scan_mux_if.sv
// ============================================================================
// Module      : display_scan_mux_if
// Description : Channel data / scan output bundle of the display scanner.
// Ports       : data_in, en_mask (master -> slave)
//               data_out, sel, anode, frame_tick (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface display_scan_mux_if
  import display_pkg::*;
#(
  parameter int N_CH   = DISP_N_CH,
  parameter int DATA_W = DISP_DATA_W
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*DATA_W-1:0] data_in;
  logic [N_CH-1:0]        en_mask;
  logic [DATA_W-1:0]      data_out;
  logic [SEL_W-1:0]       sel;
  logic [N_CH-1:0]        anode;
  logic                   frame_tick;

  modport master (
    output data_in, en_mask,
    input  data_out, sel, anode, frame_tick
  );

  modport slave (
    input  data_in, en_mask,
    output data_out, sel, anode, frame_tick
  );

endinterface

`default_nettype wire

// File: rtl/display_scan_mux_prescaler.sv
// ============================================================================
// Module      : scan_prescaler
// Description : Slot counter for the display scanner. Counts 0..DIGIT_CYC-1.
// Ports       : clk, reset (async, active high)
//               slot_end - current cycle is the last of the slot
//               in_blank - position entered at the next edge is in the
//                          blank gap (lets the caller register the anodes)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_prescaler
  import display_pkg::*;
#(
  parameter int DIGIT_CYC = DISP_DIGIT_CYC,
  parameter int BLANK_CYC = DISP_BLANK_CYC
) (
  input  wire logic clk,
  input  wire logic reset,
  output logic      slot_end,
  output logic      in_blank
);

  localparam int               CNT_W = $clog2(DIGIT_CYC);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGIT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    slot_end = (cnt_q == LAST);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    in_blank = (32'(cnt_d) < 32'(BLANK_CYC));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_mux.sv
// ============================================================================
// Module      : display_scan_mux
// Description : Time-multiplexed seven-segment scanner. Steps through the
//               enabled channels one slot at a time, drives the active-low
//               anode with a blank gap at each slot start, and flags the
//               start of each frame.
// Ports       : clk, reset (async, active high), bus (display_scan_mux_if.slave)
// Config      : SCAN_SNAPSHOT_EN - sample data_in once per frame into a
//               shadow register so a frame never mixes old and new values.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_CH      = DISP_N_CH,
  parameter int DATA_W    = DISP_DATA_W,
  parameter int DIGIT_CYC = DISP_DIGIT_CYC,
  parameter int BLANK_CYC = DISP_BLANK_CYC
) (
  input  wire logic          clk,
  input  wire logic          reset,
  display_scan_mux_if.slave  bus
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int FLAT_W = N_CH * DATA_W;

  logic slot_end;
  logic in_blank;

  scan_prescaler #(
    .DIGIT_CYC (DIGIT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .slot_end (slot_end),
    .in_blank (in_blank)
  );

  logic [SEL_W-1:0]  sel_q,        sel_d;
  logic [N_CH-1:0]   anode_q,      anode_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic              frame_tick_q, frame_tick_d;
  logic              mask_any;

  logic [FLAT_W-1:0] src_flat;
  logic [DATA_W-1:0] src_ch [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign src_ch[k] = src_flat[k*DATA_W +: DATA_W];
  end

  // Channel selection, anode drive and frame marker for the next cycle.
  always_comb begin
    mask_any     = |bus.en_mask;
    sel_d        = sel_q;
    frame_tick_d = 1'b0;
    if (slot_end && mask_any) begin
      sel_d        = SEL_W'(next_enabled(32'(sel_q), 32'(bus.en_mask), N_CH));
      frame_tick_d = (32'(sel_d) == lowest_enabled(32'(bus.en_mask), N_CH));
    end
    // Gating uses the live mask so a cleared channel goes dark next cycle.
    anode_d = '1;
    if (!in_blank && bus.en_mask[sel_d]) anode_d[sel_d] = 1'b0;
  end

`ifdef SCAN_SNAPSHOT_EN
  logic [FLAT_W-1:0] shadow_q,    shadow_d;
  logic              load_pend_q, load_pend_d;
  logic              load;

  // On the load edge the incoming sample bypasses the shadow so the first
  // digit of the new frame already shows it.
  always_comb begin
    load        = load_pend_q | frame_tick_d;
    src_flat    = load ? bus.data_in : shadow_q;
    shadow_d    = src_flat;
    load_pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q    <= '0;
      load_pend_q <= 1'b1;
    end else begin
      shadow_q    <= shadow_d;
      load_pend_q <= load_pend_d;
    end
  end
`else
  assign src_flat = bus.data_in;
`endif

  // With nothing enabled the display freezes on its last value.
  always_comb begin
    data_out_d = mask_any ? src_ch[sel_d] : data_out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q        <= '0;
      anode_q      <= '1;
      data_out_q   <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      anode_q      <= anode_d;
      data_out_q   <= data_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.anode      = anode_q;
  assign bus.data_out   = data_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_mux.sv
// ============================================================================
// Module      : tb_display_scan_mux
// Description : Self-checking bench for display_scan_mux (8 ch, 4 bit,
//               4-cycle slots, 1-cycle blank). A cycle model predicts all
//               outputs; directed literal checks pin key moments.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_scan_mux;

  localparam int N     = 8;
  localparam int W     = 4;
  localparam int DIGIT = 4;
  localparam int BLANK = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  display_scan_mux_if #(.N_CH(N), .DATA_W(W)) bus ();

  display_scan_mux #(
    .N_CH(N), .DATA_W(W), .DIGIT_CYC(DIGIT), .BLANK_CYC(BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt   = 0;
  int          m_sel   = 0;
  logic        m_first = 1'b1;
  logic [31:0] m_shadow = '0;
  logic [3:0]  e_data  = '0;
  logic [7:0]  e_anode = 8'hFF;
  logic        e_tick  = 1'b0;
  logic [31:0] m_src;
  logic        m_load;
  logic        m_found;
  int          m_low;
  int          m_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_sel = 0; m_first = 1'b1; m_shadow = '0;
      e_data = '0; e_anode = 8'hFF; e_tick = 1'b0;
    end else begin
      e_tick = 1'b0;
      if (m_cnt == DIGIT - 1) begin
        m_cnt = 0;
        if (bus.en_mask != 0) begin
          m_found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            m_c = (m_sel + k) % N;
            if (!m_found && bus.en_mask[m_c]) begin m_sel = m_c; m_found = 1'b1; end
          end
          m_low = -1;
          for (int k = N - 1; k >= 0; k--) if (bus.en_mask[k]) m_low = k;
          e_tick = (m_sel == m_low);
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
`ifdef SCAN_SNAPSHOT_EN
      m_load = m_first || e_tick;
      m_src  = m_load ? bus.data_in : m_shadow;
      if (m_load) m_shadow = bus.data_in;
`else
      m_load = 1'b0;
      m_src  = bus.data_in;
`endif
      m_first = 1'b0;
      if (bus.en_mask != 0) e_data = 4'((m_src >> (4 * m_sel)) & 32'hF);
      if (m_cnt < BLANK || !bus.en_mask[m_sel]) e_anode = 8'hFF;
      else                                      e_anode = ~(8'h01 << m_sel);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("model_sel",   32'(bus.sel),        32'(m_sel));
    check("model_data",  32'(bus.data_out),   32'(e_data));
    check("model_anode", 32'(bus.anode),      32'(e_anode));
    check("model_tick",  32'(bus.frame_tick), 32'(e_tick));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_sel(input int v);
    int k;
    k = 0;
    while (bus.sel !== 3'(v) && k < 100) begin step(1); k++; end
    if (k >= 100) check("wait_sel_timeout", 32'(k), 32'(0));
  endtask

  int edges;
  int ghost;
  logic seen;
  logic [3:0] exp_a;

  initial begin
    bus.en_mask = 8'hFF;
    bus.data_in = 32'h76543210;
    reset = 1'b1;
    step(3);
    check("reset_anode", 32'(bus.anode), 32'hFF);
    check("reset_sel",   32'(bus.sel),   32'h0);
    check("reset_data",  32'(bus.data_out), 32'h0);
    check("reset_tick",  32'(bus.frame_tick), 32'h0);
    reset = 1'b0;

    // full scan, all channels
    step(1);
    check("e1_anode", 32'(bus.anode), 32'hFE);
    check("e1_sel",   32'(bus.sel),   32'h0);
    step(3);
    check("e4_sel",   32'(bus.sel),   32'h1);
    check("e4_anode", 32'(bus.anode), 32'hFF);
    check("e4_data",  32'(bus.data_out), 32'h1);
    step(1);
    check("e5_anode", 32'(bus.anode), 32'hFD);
    edges = 5; seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      step(1); edges++;
      if (bus.frame_tick === 1'b1) seen = 1'b1;
    end
    check("first_tick_edge", 32'(edges), 32'd32);
    check("wrap_sel", 32'(bus.sel), 32'h0);

    // sparse mask 1000_0101
    bus.en_mask = 8'b1000_0101;
    step(4);
    check("sparse_sel2",  32'(bus.sel), 32'h2);
    check("sparse_data2", 32'(bus.data_out), 32'h2);
    step(4);
    check("sparse_sel7",   32'(bus.sel),   32'h7);
    check("sparse_blank7", 32'(bus.anode), 32'hFF);
    step(1);
    check("sparse_anode7", 32'(bus.anode), 32'h7F);
    step(3);
    check("sparse_sel0",  32'(bus.sel),        32'h0);
    check("sparse_tick",  32'(bus.frame_tick), 32'h1);

    // all channels masked off for 20 cycles
    bus.en_mask = 8'h00;
    bus.data_in = 32'h76543219;
    ghost = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (bus.anode !== 8'hFF || bus.frame_tick !== 1'b0) ghost++;
    end
    check("mask0_ghost", 32'(ghost), 32'h0);
    check("mask0_sel",   32'(bus.sel), 32'h0);
    check("mask0_hold",  32'(bus.data_out), 32'h0);

    // channel 3 value change while it is displayed
    bus.data_in = 32'h76543210;
    bus.en_mask = 8'hFF;
    wait_sel(3);
    bus.data_in = 32'h7654A210;
    step(1);
`ifdef SCAN_SNAPSHOT_EN
    exp_a = 4'h3;
`else
    exp_a = 4'hA;
`endif
    check("ch3_change_next", 32'(bus.data_out), 32'(exp_a));
    wait_sel(4);
    wait_sel(3);
    check("ch3_next_frame", 32'(bus.data_out), 32'hA);

    // asynchronous reset mid-slot
    wait_sel(5);
    step(2);
    reset = 1'b1;
    #1;
    check("async_anode", 32'(bus.anode), 32'hFF);
    check("async_sel",   32'(bus.sel),   32'h0);
    check("async_data",  32'(bus.data_out), 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1);
    check("rst_slot_a", 32'(bus.anode), 32'hFE);
    step(2);
    check("rst_slot_c", 32'(bus.anode), 32'hFE);
    check("rst_slot_sel", 32'(bus.sel), 32'h0);
    step(1);
    check("rst_next_sel", 32'(bus.sel), 32'h1);
    check("rst_next_blank", 32'(bus.anode), 32'hFF);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule

`default_nettype wire
